fmps_tx_arbiter: RTL
====================

FMPS_TX_ARBITER -- requirements
Module: fmps_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 4, number of FMPS AXI-stream packet sources (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, stream data width.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, width of each statistics counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port auroraUserClk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port auroraUserReset  input  1  synchronous active-high reset.
REQ-007 SHALL have port auroraChannelUp  input  1  Aurora link up.
REQ-008 SHALL have port auroraFAstrobe  input  1  start of FA readout session.
REQ-009 SHALL have port sourceEnable  input  NUM_SOURCES  per-source arbitration enable.
REQ-010 SHALL have port s_tdata  input  NUM_SOURCES*DATA_WIDTH  source data; source i at [i*DATA_WIDTH+:DATA_WIDTH].
REQ-011 SHALL have ports s_tvalid, s_tlast  input  NUM_SOURCES each, and s_tready  output  NUM_SOURCES.
REQ-012 SHALL have ports m_tdata  output  DATA_WIDTH, m_tvalid and m_tlast  output  1, and m_tready  input  1; this is the Aurora TX stream.
REQ-013 SHALL have port packetCount  output  NUM_SOURCES*COUNT_WIDTH  packets forwarded per source.
REQ-014 SHALL have port dropCount  output  COUNT_WIDTH  packets flushed on link loss.
REQ-015 SHALL have ports grantIndex  output  clog2(NUM_SOURCES)  and dbgState  output  2.

Function
REQ-016 SHALL implement states IDLE=0, XFER=1 and FLUSH=2, with dbgState equal to the current state.
REQ-017 IDLE: a source is eligible when s_tvalid=1 and sourceEnable=1; SHALL register grant to the first eligible source searching from rrPtr+1 modulo NUM_SOURCES, then go to XFER; SHALL do nothing when no source is eligible or auroraChannelUp=0.
REQ-018 XFER: SHALL drive m_tdata, m_tvalid and m_tlast from the granted source and s_tready[grant]=m_tready, with zero added latency; all other s_tready=0.
REQ-019 XFER: on a beat with m_tvalid & m_tready & m_tlast, SHALL increment packetCount[grant] (wrapping), set rrPtr<=grant and return to IDLE.
REQ-020 SHALL hold the grant until tlast; sourceEnable changes SHALL take effect only at the next IDLE decision.
REQ-021 Latency: SHALL forward the first beat no earlier than 1 cycle after eligibility is seen in IDLE; exactly 1 idle cycle SHALL separate back-to-back packets.
REQ-022 XFER with auroraChannelUp=0: SHALL go to FLUSH in the same cycle, with m_tvalid=0 from that cycle on.
REQ-023 FLUSH: SHALL drive s_tready[grant]=1 and m_tvalid=0, discarding beats; on the granted source's tlast beat SHALL increment dropCount (saturating at all-ones), set rrPtr<=grant and go to IDLE.
REQ-024 auroraFAstrobe in IDLE: SHALL set rrPtr<=NUM_SOURCES-1 so that source 0 has next priority.
REQ-025 auroraFAstrobe in XFER or FLUSH: SHALL set a pending flag; on exit to IDLE, rrPtr<=NUM_SOURCES-1 SHALL override rrPtr<=grant, and the pending flag SHALL clear.
REQ-026 Outside XFER: m_tvalid=0 and m_tlast=0; m_tdata value is don't-care but SHALL be driven to 0.
REQ-027 grantIndex SHALL equal the registered grant at all times.

Reset
REQ-028 Reset SHALL set state=IDLE, rrPtr=NUM_SOURCES-1, grant=0, pending=0, all packetCount=0, dropCount=0, m_tvalid=0, m_tlast=0, m_tdata=0, and all s_tready=0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet without counting it; sources are responsible for their own flush.

Structure
REQ-030 A shared package SHALL hold the state encodings and the clog2 index-width helper.
REQ-031 The module SHALL use one sub-module, rr_priority_pick, a combinational rotate-and-find-first that takes request, pointer and enable and returns a valid flag and an index.

Verification
REQ-032 Sources 0 and 2 each hold a 2-beat packet while IDLE with rrPtr=3 -> source 0 is forwarded, 1 idle cycle, then source 2; packetCount[0]=packetCount[2]=1.
REQ-033 All 4 sources valid continuously -> grant order 0,1,2,3,0; no beat is lost with m_tready toggling 50%.
REQ-034 auroraChannelUp drops after beat 1 of a 3-beat packet from source 1 -> m_tvalid=0 that cycle; s_tready[1]=1 until tlast; dropCount=1; state returns to IDLE.
REQ-035 auroraFAstrobe during XFER of source 2, with sources 0 and 3 pending -> source 0 is granted next, not source 3.
REQ-036 sourceEnable=4'b1011 with all sources valid -> source 2 is never granted; packetCount[2] stays 0.
REQ-037 dropCount preloaded to all-ones by repeated flushes -> it stays all-ones after a further flush.

Source files
------------

// File: rtl/fmps_tx_arbiter_pkg.sv
// Shared definitions for the FMPS Aurora TX arbiter: FSM encodings and index sizing.
package fmps_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } arbState_t;

  // Width of an index able to address n sources; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmps_tx_arbiter_if.sv
// Source-side and Aurora-side AXI-stream bundle of the FMPS TX arbiter.
interface fmps_tx_arbiter_if #(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 32
);

  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SOURCES-1:0]            s_tvalid;
  logic [NUM_SOURCES-1:0]            s_tlast;
  logic [NUM_SOURCES-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]             m_tdata;
  logic                              m_tvalid;
  logic                              m_tlast;
  logic                              m_tready;

  // The arbiter consumes the source streams and drives the Aurora TX stream.
  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/fmps_tx_arbiter_rr_priority_pick.sv
// Round-robin pick: first source with request & enable, searching upward from pointer+1
// modulo NUM_SOURCES. Purely combinational.
module rr_priority_pick
  import fmps_tx_arbiter_pkg::*;
#(
  parameter  int NUM_SOURCES = 4,
  localparam int IDX_W       = idxWidth(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] request,
  input  logic [IDX_W-1:0]       pointer,
  input  logic [NUM_SOURCES-1:0] enable,
  output logic                   valid,
  output logic [IDX_W-1:0]       index
);

  logic [NUM_SOURCES-1:0] eligible;

  assign eligible = request & enable;

  // Walk candidates from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] candIdx;
    valid   = 1'b0;
    index   = '0;
    cand    = 0;
    candIdx = '0;
    for (int k = NUM_SOURCES; k >= 1; k--) begin
      cand    = (int'(pointer) + k) % NUM_SOURCES;
      candIdx = IDX_W'(cand);
      valid   = valid | eligible[candIdx];
      index   = eligible[candIdx] ? candIdx : index;
    end
  end

endmodule

// File: rtl/fmps_tx_arbiter.sv
// Packet-granular round-robin arbiter merging FMPS source streams onto the Aurora TX
// stream, flushing the in-flight packet when the channel drops.
module fmps_tx_arbiter
  import fmps_tx_arbiter_pkg::*;
#(
  parameter  int NUM_SOURCES = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int COUNT_WIDTH = 16,
  localparam int IDX_W       = idxWidth(NUM_SOURCES)
) (
  input  logic                               auroraUserClk,
  input  logic                               auroraUserReset,
  input  logic                               auroraChannelUp,
  input  logic                               auroraFAstrobe,
  input  logic [NUM_SOURCES-1:0]             sourceEnable,
  fmps_tx_arbiter_if.master                  axis,
  output logic [NUM_SOURCES*COUNT_WIDTH-1:0] packetCount,
  output logic [COUNT_WIDTH-1:0]             dropCount,
  output logic [IDX_W-1:0]                   grantIndex,
  output logic [1:0]                         dbgState
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SOURCES - 1);

  arbState_t              state;
  arbState_t              stateNext;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       grantNext;
  logic [IDX_W-1:0]       rrPtr;
  logic [IDX_W-1:0]       rrPtrNext;
  logic [IDX_W-1:0]       exitPtr;
  logic                   pending;
  logic                   pendingNext;
  logic                   pktInc;
  logic                   dropInc;
  logic                   pickValid;
  logic [IDX_W-1:0]       pickIndex;
  logic [DATA_WIDTH-1:0]  grantData;
  logic                   grantValid;
  logic                   grantLast;
  logic [COUNT_WIDTH-1:0] pktCnt [NUM_SOURCES];

  rr_priority_pick #(
    .NUM_SOURCES (NUM_SOURCES)
  ) uPick (
    .request (axis.s_tvalid),
    .pointer (rrPtr),
    .enable  (sourceEnable),
    .valid   (pickValid),
    .index   (pickIndex)
  );

  assign grantData  = axis.s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign grantValid = axis.s_tvalid[grant];
  assign grantLast  = axis.s_tlast[grant];

  // A session strobe seen during a packet (or pending from earlier) re-homes priority to source 0.
  assign exitPtr = (pending | auroraFAstrobe) ? LAST_IDX : grant;

  // Next-state, grant bookkeeping and the zero-latency stream mux.
  always_comb begin
    stateNext     = state;
    grantNext     = grant;
    rrPtrNext     = rrPtr;
    pendingNext   = pending;
    pktInc        = 1'b0;
    dropInc       = 1'b0;
    axis.m_tdata  = '0;
    axis.m_tvalid = 1'b0;
    axis.m_tlast  = 1'b0;
    axis.s_tready = '0;
    if (auroraUserReset) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          rrPtrNext = auroraFAstrobe ? LAST_IDX : rrPtr;
          if (auroraChannelUp && pickValid) begin
            grantNext = pickIndex;
            stateNext = XFER;
          end else begin
            stateNext = IDLE;
          end
        end
        XFER: begin
          pendingNext = pending | auroraFAstrobe;
          if (!auroraChannelUp) begin
            stateNext = FLUSH;
          end else begin
            axis.m_tdata         = grantData;
            axis.m_tvalid        = grantValid;
            axis.m_tlast         = grantLast;
            axis.s_tready[grant] = axis.m_tready;
            if (grantValid && axis.m_tready && grantLast) begin
              pktInc      = 1'b1;
              rrPtrNext   = exitPtr;
              pendingNext = 1'b0;
              stateNext   = IDLE;
            end else begin
              stateNext = XFER;
            end
          end
        end
        FLUSH: begin
          pendingNext          = pending | auroraFAstrobe;
          axis.s_tready[grant] = 1'b1;
          if (grantValid && grantLast) begin
            dropInc     = 1'b1;
            rrPtrNext   = exitPtr;
            pendingNext = 1'b0;
            stateNext   = IDLE;
          end else begin
            stateNext = FLUSH;
          end
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  // Arbitration state registers.
  always_ff @(posedge auroraUserClk) begin
    if (auroraUserReset) begin
      state   <= IDLE;
      grant   <= '0;
      rrPtr   <= LAST_IDX;
      pending <= 1'b0;
    end else begin
      state   <= stateNext;
      grant   <= grantNext;
      rrPtr   <= rrPtrNext;
      pending <= pendingNext;
    end
  end

  // Statistics: per-source forwarded packets wrap, flushed packets saturate.
  always_ff @(posedge auroraUserClk) begin
    if (auroraUserReset) begin
      dropCount <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        pktCnt[i] <= '0;
      end
    end else begin
      if (pktInc) begin
        pktCnt[grant] <= pktCnt[grant] + COUNT_WIDTH'(1);
      end
      if (dropInc && (dropCount != {COUNT_WIDTH{1'b1}})) begin
        dropCount <= dropCount + COUNT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : gPack
    assign packetCount[g*COUNT_WIDTH +: COUNT_WIDTH] = pktCnt[g];
  end

  assign grantIndex = grant;
  assign dbgState   = state;

endmodule
